ecc_scalar_sequencer: RTL and testbench

Left-to-right double-and-add scheduler for the elliptic curve processor. It latches a scalar and walks its bits from MSB to LSB with an internal mod-2^IDX_W bit-index down counter. For each bit it issues point-double and, when needed, point-add requests to the shared point-arithmetic datapath over a req/ack handshake. It sits between the top-level command interface and the point datapath, and signals completion.

---
 rtl/ecc_scalar_sequencer.sv | 138 +++++++++++++
 tb/tb_ecc_scalar_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scalar_sequencer.sv
// Left-to-right double-and-add scheduler: walks the latched scalar MSB->LSB and
// issues DBL/ADD (and LOAD when SEQ_LZ_SKIP_EN skips leading zeros) over op_req/op_ack.
module ecc_scalar_sequencer #(
    parameter int KEY_W = 512,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] scalar,
    input  logic             op_ack,
    output logic             op_req,
    output logic [1:0]       op_code,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic             zero_scalar
);

    // Handshake: op_req is a level held with op_code/bit_idx stable until the
    // cycle op_ack is sampled high; an ack while op_req is low has no effect.
    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DBL, S_ADD, S_LOAD, S_NEXT, S_DONE
    } state_t;

    localparam logic [1:0]       OP_NONE = 2'b00;
    localparam logic [1:0]       OP_DBL  = 2'b01;
    localparam logic [1:0]       OP_ADD  = 2'b10;
    localparam logic [1:0]       OP_LOAD = 2'b11;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(KEY_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state;
    logic [KEY_W-1:0] k;
    logic [KEY_W-1:0] k_shift;
    logic             cur_bit;

    // Shift rather than index so the counter may be wider than log2(KEY_W).
    assign k_shift = k >> bit_idx;
    assign cur_bit = k_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k           <= '0;
            op_req      <= 1'b0;
            op_code     <= OP_NONE;
            bit_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            zero_scalar <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k           <= scalar;
                        bit_idx     <= TOP_IDX;
                        busy        <= 1'b1;
                        zero_scalar <= 1'b0;
`ifdef SEQ_LZ_SKIP_EN
                        state       <= S_SCAN;
`else
                        state       <= S_DBL;
                        op_req      <= 1'b1;
                        op_code     <= OP_DBL;
`endif
                    end
                end
`ifdef SEQ_LZ_SKIP_EN
                S_SCAN: begin
                    if (cur_bit) begin
                        state   <= S_LOAD;
                        op_req  <= 1'b1;
                        op_code <= OP_LOAD;
                    end else if (bit_idx == '0) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        zero_scalar <= ~|k;
                    end else begin
                        bit_idx <= bit_idx - IDX_ONE;
                    end
                end
                S_LOAD: begin
                    if (op_ack) begin
                        state   <= S_NEXT;
                        op_req  <= 1'b0;
                        op_code <= OP_NONE;
                    end
                end
`endif
                S_DBL: begin
                    if (op_ack) begin
                        if (cur_bit) begin
                            // Back-to-back: ADD request follows the DBL ack with no bubble.
                            state   <= S_ADD;
                            op_code <= OP_ADD;
                        end else begin
                            state   <= S_NEXT;
                            op_req  <= 1'b0;
                            op_code <= OP_NONE;
                        end
                    end
                end
                S_ADD: begin
                    if (op_ack) begin
                        state   <= S_NEXT;
                        op_req  <= 1'b0;
                        op_code <= OP_NONE;
                    end
                end
                S_NEXT: begin
                    if (bit_idx == '0) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        zero_scalar <= ~|k;
                    end else begin
                        bit_idx <= bit_idx - IDX_ONE;
                        state   <= S_DBL;
                        op_req  <= 1'b1;
                        op_code <= OP_DBL;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    op_req  <= 1'b0;
                    op_code <= OP_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scalar_sequencer.sv
// Scoreboard bench for ecc_scalar_sequencer with KEY_W=4; expected op streams are
// hand-derived for both builds (SEQ_LZ_SKIP_EN defined or not).
module tb_ecc_scalar_sequencer;

    localparam int KEY_W = 4;
    localparam int IDX_W = 2;
    localparam int EW    = 4 + IDX_W;

    localparam logic [1:0] C_DBL  = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_LOAD = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [KEY_W-1:0] scalar;
    logic             op_ack;
    logic             op_req;
    logic [1:0]       op_code;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    logic             zero_scalar;

    ecc_scalar_sequencer #(.KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scalar(scalar),
        .op_ack(op_ack), .op_req(op_req), .op_code(op_code), .bit_idx(bit_idx),
        .busy(busy), .done(done), .zero_scalar(zero_scalar)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int add_delay = 0;
    int spur_left = 0;
    bit ack_en    = 1'b1;

    function automatic logic [EW-1:0] op_ev(input logic [1:0] c, input logic [IDX_W-1:0] i);
        return {1'b0, 1'b0, c, i};
    endfunction

    function automatic logic [EW-1:0] done_ev(input logic zs);
        return {1'b1, zs, 2'b00, {IDX_W{1'b0}}};
    endfunction

    task automatic check_ev(input logic [EW-1:0] got, input string name);
        logic [EW-1:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event got=%h, none expected", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got=%h expected=%h", name, got, exp);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (op_req && op_ack) begin
                check_ev(op_ev(op_code, bit_idx), "op");
                check_val("busy_during_op", {7'd0, busy}, 8'd1);
            end
            if (done) begin
                check_ev(done_ev(zero_scalar), "done");
                check_val("busy_at_done", {7'd0, busy}, 8'd0);
                done_cnt++;
            end
        end
    end

    // ---------------- datapath ack driver ----------------
    initial begin
        logic [1:0]       c;
        logic [IDX_W-1:0] i;
        int               d;
        op_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && op_req) begin
                c = op_code;
                i = bit_idx;
                d = (c == C_ADD) ? add_delay : 0;
                for (int n = 0; n < d; n++) begin
                    check_val("hold_req", {7'd0, op_req}, 8'd1);
                    check_val("hold_code", {6'd0, op_code}, {6'd0, c});
                    check_val("hold_idx", {{(8-IDX_W){1'b0}}, bit_idx}, {{(8-IDX_W){1'b0}}, i});
                    @(negedge clk);
                end
                op_ack = 1'b1;
                @(negedge clk);
                op_ack = 1'b0;
            end else if (ack_en && spur_left > 0) begin
                // op_req is low going into the next edge, so this ack must be ignored.
                op_ack = 1'b1;
                @(negedge clk);
                op_ack = 1'b0;
                spur_left--;
            end
        end
    end

    // ---------------- stimulus driver ----------------
    task automatic pulse_start(input logic [KEY_W-1:0] s);
        @(negedge clk);
        start  = 1'b1;
        scalar = s;
        @(negedge clk);
        start  = 1'b0;
        scalar = '0;
    endtask

    task automatic run(input logic [KEY_W-1:0] s, input int addd, input bit inject);
        int base;
        int cyc;
        add_delay = addd;
        base = done_cnt;
        pulse_start(s);
        if (inject) begin
            spur_left = 3;
            repeat (2) @(negedge clk);
            pulse_start(4'b1111);
            repeat (2) @(negedge clk);
            pulse_start(4'b0001);
        end
        cyc = 0;
        while (done_cnt == base && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done_cnt == base) begin
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles (scalar=%h)", cyc, s);
        end
        repeat (3) @(negedge clk);
        check_val("queue_drained", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
        spur_left = 0;
    endtask

    task automatic push_1010();
`ifdef SEQ_LZ_SKIP_EN
        exp_q.push_back(op_ev(C_LOAD, 2'd3));
`else
        exp_q.push_back(op_ev(C_DBL, 2'd3));
        exp_q.push_back(op_ev(C_ADD, 2'd3));
`endif
        exp_q.push_back(op_ev(C_DBL, 2'd2));
        exp_q.push_back(op_ev(C_DBL, 2'd1));
        exp_q.push_back(op_ev(C_ADD, 2'd1));
        exp_q.push_back(op_ev(C_DBL, 2'd0));
        exp_q.push_back(done_ev(1'b0));
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        start  = 1'b0;
        scalar = '0;
        repeat (3) @(negedge clk);
        #1;
        // reset state
        check_val("rst_op_req", {7'd0, op_req}, 8'd0);
        check_val("rst_op_code", {6'd0, op_code}, 8'd0);
        check_val("rst_bit_idx", {{(8-IDX_W){1'b0}}, bit_idx}, 8'd0);
        check_val("rst_busy", {7'd0, busy}, 8'd0);
        check_val("rst_done", {7'd0, done}, 8'd0);
        check_val("rst_zero", {7'd0, zero_scalar}, 8'd0);
        rst_n = 1'b1;

        // scalar 1010, prompt acks
        push_1010();
        run(4'b1010, 0, 1'b0);
        check_val("zero_after_1010", {7'd0, zero_scalar}, 8'd0);

        // zero scalar
`ifndef SEQ_LZ_SKIP_EN
        exp_q.push_back(op_ev(C_DBL, 2'd3));
        exp_q.push_back(op_ev(C_DBL, 2'd2));
        exp_q.push_back(op_ev(C_DBL, 2'd1));
        exp_q.push_back(op_ev(C_DBL, 2'd0));
`endif
        exp_q.push_back(done_ev(1'b1));
        run(4'b0000, 0, 1'b0);
        check_val("zero_held_idle", {7'd0, zero_scalar}, 8'd1);

        // scalar 0110 with ADD acks held off 5 cycles
`ifdef SEQ_LZ_SKIP_EN
        exp_q.push_back(op_ev(C_LOAD, 2'd2));
`else
        exp_q.push_back(op_ev(C_DBL, 2'd3));
        exp_q.push_back(op_ev(C_DBL, 2'd2));
        exp_q.push_back(op_ev(C_ADD, 2'd2));
`endif
        exp_q.push_back(op_ev(C_DBL, 2'd1));
        exp_q.push_back(op_ev(C_ADD, 2'd1));
        exp_q.push_back(op_ev(C_DBL, 2'd0));
        exp_q.push_back(done_ev(1'b0));
        run(4'b0110, 5, 1'b0);
        check_val("zero_cleared", {7'd0, zero_scalar}, 8'd0);

        // 1010 again with ignored starts and spurious acks mid-run
        push_1010();
        run(4'b1010, 0, 1'b1);

        // asynchronous reset in the middle of a request
        ack_en = 1'b0;
        pulse_start(4'b1010);
        cyc = 0;
        while (!op_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("req_before_reset", {7'd0, op_req}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_op_req", {7'd0, op_req}, 8'd0);
        check_val("async_op_code", {6'd0, op_code}, 8'd0);
        check_val("async_bit_idx", {{(8-IDX_W){1'b0}}, bit_idx}, 8'd0);
        check_val("async_busy", {7'd0, busy}, 8'd0);
        check_val("async_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;

        // normal operation after the abandoned request
        push_1010();
        run(4'b1010, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
